// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for an N x N systolic PE array.
// It accepts one K-step beat per handshake: an A column vector and a B row vector.
// Lane i of each vector passes through a delay chain that is i+1 registers deep, which
// creates the diagonal skew. The feeder also produces the array-wide hold
// (complete_flag), the accumulator clear, the zero-flush cycles and a done pulse.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, k_len    job request and inner dimension, sampled only in IDLE
//   in_valid        beat valid; a beat is accepted while in_ready is high
//   in_ready        feeder accepts a beat (FEED state)
//   a_vec, b_vec    A column (lane i -> row i) and B row (lane j -> column j)
//   west_row_out    skewed row data to PE column 0
//   north_col_out   skewed column data to PE row 0
//   complete_flag   1 = all PEs hold, 0 = PEs compute and shift
//   acc_clr         one-cycle pulse that clears the array sums
//   busy            high in any state other than IDLE
//   done            one-cycle pulse when all N*N sums are final
// N must be at least 2.
module systolic_skew_feeder #(
  parameter int unsigned N    = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned KMAX = 256,
  parameter int unsigned KW   = $clog2(KMAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic [N*DW-1:0] west_row_out,
  output logic [N*DW-1:0] north_col_out,
  output logic          complete_flag,
  output logic          acc_clr,
  output logic          busy,
  output logic          done
);

  // The last beat needs 2N-2 extra shifts to reach PE(N-1,N-1).
  localparam int unsigned FlushLen = 2 * N - 2;
  localparam int unsigned FW       = (FlushLen > 1) ? $clog2(FlushLen) : 1;

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e state_q, state_d;

  logic [KW-1:0] k_len_q;
  logic [KW-1:0] beat_cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic          cflag_q;
  logic          acc_clr_q;
  logic          done_q;

  logic advance;
  logic job_start;
  logic flushing;
  logic last_beat;
  logic flush_last;

  logic [N*DW-1:0] inj_a;
  logic [N*DW-1:0] inj_b;

  assign last_beat  = (beat_cnt_q + KW'(1)) == k_len_q;
  assign flush_last = flush_cnt_q == FW'(FlushLen - 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (k_len != '0) ? StFeed : StDrain;
      StFeed:  if (in_valid && last_beat) state_d = StFlush;
      StFlush: if (flush_last) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    advance   = 1'b0;
    job_start = 1'b0;
    flushing  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        job_start = start && (k_len != '0);
      end
      StFeed: begin
        in_ready = 1'b1;
        advance  = in_valid;
      end
      StFlush: begin
        advance  = 1'b1;
        flushing = 1'b1;
      end
      StDrain: ;
      default: busy = 1'b0;
    endcase
  end

  // Counters and registered control pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      cflag_q     <= 1'b1;
      acc_clr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Hold is registered so it lines up with the skewed data one cycle later.
      cflag_q   <= ~advance;
      acc_clr_q <= job_start;
      done_q    <= (state_q == StDrain);
      if (job_start) begin
        k_len_q    <= k_len;
        beat_cnt_q <= '0;
      end else if (in_ready && in_valid) begin
        beat_cnt_q <= beat_cnt_q + KW'(1);
      end
      if (state_q == StFlush) begin
        flush_cnt_q <= flush_cnt_q + FW'(1);
      end else begin
        flush_cnt_q <= '0;
      end
    end
  end

  assign complete_flag = cflag_q;
  assign acc_clr       = acc_clr_q;
  assign done          = done_q;

  assign inj_a = flushing ? '0 : a_vec;
  assign inj_b = flushing ? '0 : b_vec;

  // Per-lane delay chains: lane i is i+1 registers deep.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_q [i+1];
    logic [DW-1:0] b_q [i+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else if (job_start) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else if (advance) begin
        a_q[0] <= inj_a[i*DW +: DW];
        b_q[0] <= inj_b[i*DW +: DW];
        for (int s = 1; s <= i; s++) begin
          a_q[s] <= a_q[s-1];
          b_q[s] <= b_q[s-1];
        end
      end
    end

    assign west_row_out[i*DW +: DW]  = a_q[i];
    assign north_col_out[i*DW +: DW] = b_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus pushes hand-computed
// (cycle, signal, value) expectations; a negedge monitor pops and compares them.
module tb_systolic_skew_feeder;
  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned KMAX = 256;
  localparam int unsigned KW   = $clog2(KMAX + 1);

  localparam int KWest = 0, KNorth = 1, KCflag = 2, KAccClr = 3, KBusy = 4, KDone = 5,
                 KReady = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] a_vec = '0;
  logic [N*DW-1:0] b_vec = '0;
  logic [N*DW-1:0] west_row_out;
  logic [N*DW-1:0] north_col_out;
  logic            complete_flag;
  logic            acc_clr;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DW(DW), .KMAX(KMAX), .KW(KW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .k_len         (k_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_vec         (a_vec),
    .b_vec         (b_vec),
    .west_row_out  (west_row_out),
    .north_col_out (north_col_out),
    .complete_flag (complete_flag),
    .acc_clr       (acc_clr),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
  } chk_t;

  chk_t  q[$];
  string names[7] = '{"west_row_out", "north_col_out", "complete_flag", "acc_clr", "busy",
                      "done", "in_ready"};
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_done = 0;
  int    base;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(int kind);
    case (kind)
      KWest:   return west_row_out;
      KNorth:  return north_col_out;
      KCflag:  return {63'b0, complete_flag};
      KAccClr: return {63'b0, acc_clr};
      KBusy:   return {63'b0, busy};
      KDone:   return {63'b0, done};
      KReady:  return {63'b0, in_ready};
      default: return '0;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    chk_t e;
    if (done === 1'b1) n_done = n_done + 1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp = n_cmp + 1;
      if (e.cyc < cyc) begin
        n_bad = n_bad + 1;
        $display("FAIL %s missed check at cycle %0d (now %0d)", names[e.kind], e.cyc, cyc);
      end else if (actual(e.kind) !== e.val) begin
        n_bad = n_bad + 1;
        $display("FAIL %s cycle %0d: got %h required %h", names[e.kind], e.cyc,
                 actual(e.kind), e.val);
      end
    end
  end

  task automatic expect_at(int c, int kind, logic [63:0] v);
    q.push_back('{c, kind, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] avec(int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'hA000 + 16'(k * 16 + i);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] bvec(int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'hB000 + 16'(k * 16 + i);
    return v;
  endfunction

  initial begin
    // Power-on reset values
    tick();
    base = cyc;
    expect_at(base, KWest, 64'h0);
    expect_at(base, KNorth, 64'h0);
    expect_at(base, KCflag, 64'h1);
    expect_at(base, KAccClr, 64'h0);
    expect_at(base, KBusy, 64'h0);
    expect_at(base, KDone, 64'h0);
    expect_at(base, KReady, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal job, k_len=3, in_valid held high
    base = cyc;
    expect_at(base + 0, KAccClr, 64'h0);
    expect_at(base + 0, KCflag, 64'h1);
    expect_at(base + 1, KAccClr, 64'h1);
    expect_at(base + 1, KReady, 64'h1);
    expect_at(base + 1, KCflag, 64'h1);
    expect_at(base + 1, KWest, 64'h0);
    expect_at(base + 2, KWest, 64'h0000_0000_0000_A000);
    expect_at(base + 2, KAccClr, 64'h0);
    expect_at(base + 2, KCflag, 64'h0);
    expect_at(base + 3, KWest, 64'h0000_0000_A001_A010);
    expect_at(base + 3, KReady, 64'h1);
    expect_at(base + 4, KWest, 64'h0000_A002_A011_A020);
    expect_at(base + 4, KNorth, 64'h0000_B002_B011_B020);
    expect_at(base + 4, KReady, 64'h0);
    expect_at(base + 5, KWest, 64'hA003_A012_A021_0000);
    expect_at(base + 6, KWest, 64'hA013_A022_0000_0000);
    expect_at(base + 7, KWest, 64'hA023_0000_0000_0000);
    expect_at(base + 7, KNorth, 64'hB023_0000_0000_0000);
    expect_at(base + 8, KWest, 64'h0);
    expect_at(base + 10, KCflag, 64'h0);
    expect_at(base + 10, KBusy, 64'h1);
    expect_at(base + 10, KDone, 64'h0);
    expect_at(base + 11, KDone, 64'h1);
    expect_at(base + 11, KBusy, 64'h0);
    expect_at(base + 11, KCflag, 64'h1);
    expect_at(base + 12, KDone, 64'h0);
    for (int c = 0; c < 14; c++) begin
      start    = (c == 0);
      k_len    = KW'(3);
      in_valid = 1'b1;
      a_vec    = avec(c - 1);
      b_vec    = bvec(c - 1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Stall: k_len=4, in_valid low for two cycles after beat 1
    base = cyc;
    expect_at(base + 3, KWest, 64'h0000_0000_A001_A010);
    expect_at(base + 3, KCflag, 64'h0);
    expect_at(base + 3, KReady, 64'h1);
    expect_at(base + 4, KWest, 64'h0000_0000_A001_A010);
    expect_at(base + 4, KCflag, 64'h1);
    expect_at(base + 5, KWest, 64'h0000_0000_A001_A010);
    expect_at(base + 5, KNorth, 64'h0000_0000_B001_B010);
    expect_at(base + 5, KCflag, 64'h1);
    expect_at(base + 6, KWest, 64'h0000_A002_A011_A020);
    expect_at(base + 6, KNorth, 64'h0000_B002_B011_B020);
    expect_at(base + 6, KCflag, 64'h0);
    expect_at(base + 12, KDone, 64'h0);
    expect_at(base + 13, KDone, 64'h0);
    expect_at(base + 13, KBusy, 64'h1);
    expect_at(base + 14, KDone, 64'h1);
    expect_at(base + 15, KDone, 64'h0);
    for (int c = 0; c < 17; c++) begin
      start    = (c == 0);
      k_len    = KW'(4);
      in_valid = !(c == 3 || c == 4);
      if (c == 3 || c == 4) begin
        a_vec = '1;
        b_vec = '1;
      end else begin
        a_vec = avec((c <= 2) ? c - 1 : c - 3);
        b_vec = bvec((c <= 2) ? c - 1 : c - 3);
      end
      tick();
    end
    in_valid = 1'b0;

    // k_len=0: straight to DRAIN
    base = cyc;
    expect_at(base + 1, KBusy, 64'h1);
    expect_at(base + 1, KAccClr, 64'h0);
    expect_at(base + 1, KReady, 64'h0);
    expect_at(base + 1, KCflag, 64'h1);
    expect_at(base + 1, KDone, 64'h0);
    expect_at(base + 2, KDone, 64'h1);
    expect_at(base + 2, KBusy, 64'h0);
    expect_at(base + 2, KCflag, 64'h1);
    expect_at(base + 3, KDone, 64'h0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      k_len = '0;
      tick();
    end

    // Second start during FLUSH must be ignored
    base = cyc;
    expect_at(base + 1, KAccClr, 64'h1);
    expect_at(base + 2, KReady, 64'h1);
    expect_at(base + 3, KReady, 64'h0);
    expect_at(base + 6, KAccClr, 64'h0);
    expect_at(base + 6, KReady, 64'h0);
    expect_at(base + 9, KBusy, 64'h1);
    expect_at(base + 9, KDone, 64'h0);
    expect_at(base + 10, KDone, 64'h1);
    expect_at(base + 10, KBusy, 64'h0);
    expect_at(base + 11, KDone, 64'h0);
    expect_at(base + 12, KBusy, 64'h0);
    for (int c = 0; c < 14; c++) begin
      start    = (c == 0 || c == 5);
      k_len    = (c == 5) ? KW'(7) : KW'(2);
      in_valid = 1'b1;
      a_vec    = avec(c - 1);
      b_vec    = bvec(c - 1);
      tick();
    end
    in_valid = 1'b0;

    // Reset mid-FEED aborts the job
    base = cyc;
    expect_at(base + 2, KWest, 64'h0000_0000_0000_A000);
    expect_at(base + 2, KBusy, 64'h1);
    expect_at(base + 3, KWest, 64'h0);
    expect_at(base + 3, KNorth, 64'h0);
    expect_at(base + 3, KCflag, 64'h1);
    expect_at(base + 3, KBusy, 64'h0);
    expect_at(base + 3, KReady, 64'h0);
    expect_at(base + 3, KAccClr, 64'h0);
    expect_at(base + 3, KDone, 64'h0);
    expect_at(base + 4, KDone, 64'h0);
    for (int c = 0; c < 3; c++) begin
      start    = (c == 0);
      k_len    = KW'(5);
      in_valid = 1'b1;
      a_vec    = avec(c - 1);
      b_vec    = bvec(c - 1);
      tick();
    end
    #1 rst_n = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Start accepted normally after reset release, k_len=1
    base = cyc;
    expect_at(base + 1, KAccClr, 64'h1);
    expect_at(base + 1, KReady, 64'h1);
    expect_at(base + 2, KReady, 64'h0);
    expect_at(base + 2, KWest, 64'h0000_0000_0000_A000);
    expect_at(base + 7, KDone, 64'h0);
    expect_at(base + 8, KDone, 64'h0);
    expect_at(base + 9, KDone, 64'h1);
    expect_at(base + 10, KBusy, 64'h0);
    for (int c = 0; c < 12; c++) begin
      start    = (c == 0);
      k_len    = KW'(1);
      in_valid = (c == 1);
      a_vec    = avec(c - 1);
      b_vec    = bvec(c - 1);
      tick();
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_cmp = n_cmp + q.size();
      n_bad = n_bad + q.size();
      $display("FAIL scoreboard_drain: %0d checks left, required 0", q.size());
    end
    n_cmp = n_cmp + 1;
    if (n_done != 5) begin
      n_bad = n_bad + 1;
      $display("FAIL done_pulse_count: got %0d required 5", n_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
